cache_assoc_ro: RTL and testbench
=================================

// Module: cache_assoc_ro
// PURPOSE
// - Parametrised N-way set-associative, read-only instruction cache between fetch stage and line-wide memory.
// - Generalises the direct-mapped cache: configurable ways/sets/line size, round-robin replacement with
//   invalid-way-first, refill keyed on latched request (not live addr_i), flush, hit/miss counters.
// - Hits: 1-cycle latency, 1 request/cycle throughput. Misses: one blocking line refill.
// PARAMETERS
// - NR_WAYS      2   ways per set, power of two, >=1
// - INDEX_BITS   5   set index bits; NR_SETS = 2**INDEX_BITS
// - OFFSET_BITS  4   byte-offset bits; LINE_W = 8*2**OFFSET_BITS, >=3
// - ADDR_W       32  address width; TAG_W = ADDR_W-INDEX_BITS-OFFSET_BITS
// - CNT_W        32  width of performance counters
// PORTS
// - clk_i             in   1       clock
// - rst_i             in   1       reset
// - addr_i            in   ADDR_W  byte address; bits [1:0] ignored
// - read_en_i         in   1       read request
// - read_valid_o      out  1       response valid, one-cycle pulse per request
// - read_word_o       out  32      response word
// - flush_i           in   1       invalidate all lines (pulse)
// - mem_addr_o        out  ADDR_W  line-aligned refill address
// - mem_read_en_o     out  1       refill request, held until mem_read_valid_i
// - mem_read_valid_i  in   1       refill data valid (single cycle)
// - mem_read_data_i   in   LINE_W  line data, word 0 in bits [31:0]
// - hit_count_o       out  CNT_W   hits since reset, saturating
// - miss_count_o      out  CNT_W   misses since reset, saturating
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-high.
// - Reset: state IDLE, all valid bits 0, RR pointers 0, all outputs 0 (mem_read_en_o drops immediately).
// - Reset mid-refill: refill abandoned, nothing installed, no response.
// - States: IDLE, REFILL. All outputs registered.
// - IDLE, flush_i=1: clear all valid bits and RR pointers at edge; read_en_i ignored this cycle
//   (request not counted; requester keeps it asserted).
// - IDLE, read_en_i=1, hit: next cycle read_valid_o=1, read_word_o = word offset[OFFSET_BITS-1:2]; hit_count++.
// - IDLE, read_en_i=1, miss: latch tag/index/word-offset; next cycle state REFILL,
//   mem_addr_o={tag,index,0}, mem_read_en_o=1; miss_count++.
// - Handshake: any cycle with read_en_i=1 in IDLE is a new request, including the cycle read_valid_o=1.
//   Requester presents next address or drops read_en_i then. addr_i must hold while read_en_i=1 and no response yet.
// - REFILL: hold mem_addr_o/mem_read_en_o until mem_read_valid_i. On that edge: write line+latched tag into
//   victim way of latched index, set valid, advance that set's RR pointer (mod NR_WAYS); mem_read_en_o=0;
//   read_valid_o=1 with latched word only if read_en_i still 1; else installed silently. Return to IDLE.
// - Victim: lowest-numbered invalid way, else way at set's RR pointer. RR advances only on refill.
// - Miss latency: mem_read_en_o at N+1; mem_read_valid_i at N+L -> read_valid_o at N+L+1.
// - flush_i during REFILL: latched pending; refill completes (line installed, response given), flush executes
//   next IDLE cycle with same priority as IDLE flush.
// - Counters saturate at all-ones; cleared only by reset.
// - Multiple ways matching same tag cannot occur; no priority logic required.
// STRUCTURE
// - cache_pkg: state enum (IDLE, REFILL), localparams TAG_W/LINE_W/NR_SETS/WORDS_PER_LINE,
//   addr-split function returning {tag,index,offset}.
// - Sub-module cache_victim_sel: per-set RR pointer storage + invalid-first victim select.
// - Tag/valid/data arrays in flops; word select via case over word index (no barrel shifter).
// TESTING (NR_WAYS=2, INDEX_BITS=5, OFFSET_BITS=4; 0x100/0x300/0x500 map to set 0x10)
// - Cold read 0x104, mem returns 128'h4444_4444_3333_3333_2222_2222_1111_1111 after 3 cycles
//   -> mem_addr_o=0x100, read_word_o=0x2222_2222, miss_count=1; then 0x10C -> hit next cycle, 0x4444_4444.
// - Hits 0x100,0x104,0x108,0x10C on consecutive cycles -> read_valid_o high 4 consecutive cycles, hit_count+=4.
// - Fill 0x100, 0x300, then 0x500 -> way0 evicted; read 0x300 hits, 0x100 misses.
// - Miss 0x100, change addr_i to 0x700 and drop read_en_i during REFILL -> no read_valid_o;
//   line installed tag of 0x100; later read 0x100 hits.
// - flush_i during REFILL of 0x100 -> response delivered, then all invalid; read 0x100 misses, miss_count+1.
// - rst_i asserted mid-REFILL -> mem_read_en_o=0 same cycle, counters 0, read 0x100 after reset misses.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared state type, default geometry and address split for the read-only cache
package cache_pkg;
    typedef enum logic {IDLE, REFILL} state_t;
    localparam int NR_WAYS_DEF     = 2;
    localparam int INDEX_BITS_DEF  = 5;
    localparam int OFFSET_BITS_DEF = 4;
    localparam int ADDR_W_DEF      = 32;
    localparam int CNT_W_DEF       = 32;
    localparam int TAG_W           = ADDR_W_DEF - INDEX_BITS_DEF - OFFSET_BITS_DEF;
    localparam int LINE_W          = 8 * (2 ** OFFSET_BITS_DEF);
    localparam int NR_SETS         = 2 ** INDEX_BITS_DEF;
    localparam int WORDS_PER_LINE  = 2 ** (OFFSET_BITS_DEF - 2);
    typedef struct packed {
        logic [TAG_W-1:0]           tag;
        logic [INDEX_BITS_DEF-1:0]  index;
        logic [OFFSET_BITS_DEF-1:0] offset;
    } addr_split_t;
    function automatic addr_split_t split_addr(input logic [ADDR_W_DEF-1:0] addr);
        return addr_split_t'(addr);
    endfunction
endpackage

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: per-set round-robin pointers and invalid-first victim choice
module cache_victim_sel #(
    parameter int NR_WAYS    = 2,
    parameter int INDEX_BITS = 5,
    localparam int WAY_W     = NR_WAYS > 1 ? $clog2(NR_WAYS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear,
    input  logic                  advance,
    input  logic [INDEX_BITS-1:0] idx,
    input  logic [NR_WAYS-1:0]    set_valid,
    output logic [WAY_W-1:0]      victim
);
    localparam int SETS = 2 ** INDEX_BITS;

    logic [WAY_W-1:0] rr [SETS];

    // lowest-numbered invalid way wins, otherwise the set's round-robin pointer
    always_comb begin
        victim = rr[idx];
        for (int w = NR_WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) victim = WAY_W'(w);
        end
    end

    // pointers move only when a line is installed, and all return to way 0 on flush
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clear) begin
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else if (advance) begin
            rr[idx] <= (rr[idx] == WAY_W'(NR_WAYS - 1)) ? '0 : rr[idx] + 1'b1;
        end
    end
endmodule

// File: rtl/cache_assoc_ro.sv
// cache_assoc_ro: N-way set-associative read-only instruction cache with blocking line refill
module cache_assoc_ro
    import cache_pkg::*;
#(
    parameter int NR_WAYS     = NR_WAYS_DEF,
    parameter int INDEX_BITS  = INDEX_BITS_DEF,
    parameter int OFFSET_BITS = OFFSET_BITS_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [ADDR_W-1:0]              addr_i,
    input  logic                           read_en_i,
    output logic                           read_valid_o,
    output logic [31:0]                    read_word_o,
    input  logic                           flush_i,
    output logic [ADDR_W-1:0]              mem_addr_o,
    output logic                           mem_read_en_o,
    input  logic                           mem_read_valid_i,
    input  logic [8*(2**OFFSET_BITS)-1:0]  mem_read_data_i,
    output logic [CNT_W-1:0]               hit_count_o,
    output logic [CNT_W-1:0]               miss_count_o
);
    localparam int TAG_BITS  = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int LINE_BITS = 8 * (2 ** OFFSET_BITS);
    localparam int SETS      = 2 ** INDEX_BITS;
    localparam int WORDS     = 2 ** (OFFSET_BITS - 2);
    localparam int WORD_W    = OFFSET_BITS - 2;
    localparam int WAY_W     = NR_WAYS > 1 ? $clog2(NR_WAYS) : 1;

    state_t                state, state_nx;
    logic [NR_WAYS-1:0]    valid [SETS];
    logic [TAG_BITS-1:0]   tags  [NR_WAYS][SETS];
    logic [LINE_BITS-1:0]  lines [NR_WAYS][SETS];
    logic [TAG_BITS-1:0]   req_tag, lat_tag;
    logic [INDEX_BITS-1:0] req_idx, lat_idx;
    logic [WORD_W-1:0]     req_word, lat_word;
    logic [1:0]            addr_unused;
    logic [LINE_BITS-1:0]  hit_line;
    logic [WAY_W-1:0]      victim;
    logic                  hit, flush_pend, do_flush, do_hit, do_miss, do_fill;

    assign {req_tag, req_idx, req_word, addr_unused} = addr_i;

    function automatic logic [31:0] pick(input logic [LINE_BITS-1:0] line, input logic [WORD_W-1:0] sel);
        pick = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (sel == WORD_W'(i)) pick = line[i*32 +: 32];
        end
    endfunction

    cache_victim_sel #(.NR_WAYS(NR_WAYS), .INDEX_BITS(INDEX_BITS)) u_victim (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear     (do_flush),
        .advance   (do_fill),
        .idx       (lat_idx),
        .set_valid (valid[lat_idx]),
        .victim    (victim)
    );

    // tag compare across every way of the addressed set; at most one way can match
    always_comb begin
        hit      = 1'b0;
        hit_line = '0;
        for (int w = 0; w < NR_WAYS; w++) begin
            if (valid[req_idx][w] && tags[w][req_idx] == req_tag) begin
                hit      = 1'b1;
                hit_line = lines[w][req_idx];
            end
        end
    end

    // per-cycle action decode and next state; a flush in IDLE shadows any request
    always_comb begin
        do_flush = state == IDLE && (flush_i || flush_pend);
        do_hit   = state == IDLE && !do_flush && read_en_i && hit;
        do_miss  = state == IDLE && !do_flush && read_en_i && !hit;
        do_fill  = state == REFILL && mem_read_valid_i;
        state_nx = do_miss ? REFILL : (do_fill ? IDLE : state);
    end

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    // registered outputs, latched miss request, deferred flush and saturating counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            read_valid_o  <= 1'b0;
            read_word_o   <= '0;
            mem_addr_o    <= '0;
            mem_read_en_o <= 1'b0;
            hit_count_o   <= '0;
            miss_count_o  <= '0;
            flush_pend    <= 1'b0;
            lat_tag       <= '0;
            lat_idx       <= '0;
            lat_word      <= '0;
        end else begin
            read_valid_o  <= do_hit || (do_fill && read_en_i);
            if (do_hit) read_word_o <= pick(hit_line, req_word);
            else if (do_fill && read_en_i) read_word_o <= pick(mem_read_data_i, lat_word);
            if (do_miss) begin
                lat_tag    <= req_tag;
                lat_idx    <= req_idx;
                lat_word   <= req_word;
                mem_addr_o <= {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
            end
            mem_read_en_o <= do_miss || (mem_read_en_o && !do_fill);
            flush_pend    <= state == REFILL && (flush_pend || flush_i);
            if (do_hit && !(&hit_count_o)) hit_count_o <= hit_count_o + 1'b1;
            if (do_miss && !(&miss_count_o)) miss_count_o <= miss_count_o + 1'b1;
        end
    end

    // valid bits: cleared by reset or flush, set for the victim way when a refill lands
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || do_flush) begin
            for (int s = 0; s < SETS; s++) valid[s] <= '0;
        end else if (do_fill) begin
            valid[lat_idx][victim] <= 1'b1;
        end
    end

    // tag and line storage need no reset because valid gates every use
    always_ff @(posedge clk_i) begin
        if (do_fill) begin
            tags[victim][lat_idx]  <= lat_tag;
            lines[victim][lat_idx] <= mem_read_data_i;
        end
    end
endmodule

// File: tb/tb_cache_assoc_ro.sv
// tb_cache_assoc_ro: directed and random checking of cache_assoc_ro against a set-level reference model
module tb_cache_assoc_ro;
    localparam int CW   = 5;
    localparam int CMAX = 31;
    localparam int WAYS = 2;
    localparam int SETS = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  addr_i = '0;
    logic         read_en_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         mem_read_valid_i = 1'b0;
    logic [127:0] mem_read_data_i = '0;
    logic         read_valid_o, mem_read_en_o;
    logic [31:0]  read_word_o, mem_addr_o;
    logic [CW-1:0] hit_count_o, miss_count_o;

    int tests = 0;
    int fails = 0;
    int mem_lat = 3;
    int mem_cnt = 0;

    // reference model state: what the cache holds per set, and the outputs it must show
    logic        m_valid [SETS][WAYS];
    logic [22:0] m_tag   [SETS][WAYS];
    int          m_rr    [SETS];
    logic        m_refill, m_fpend;
    logic [31:0] m_addr;
    int          m_set, m_way, m_inv;
    logic        e_rv, e_mre;
    logic [31:0] e_word, e_maddr;
    int          e_hits, e_miss;

    always #5 clk = ~clk;

    cache_assoc_ro #(.NR_WAYS(2), .INDEX_BITS(5), .OFFSET_BITS(4), .ADDR_W(32), .CNT_W(CW)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .addr_i           (addr_i),
        .read_en_i        (read_en_i),
        .read_valid_o     (read_valid_o),
        .read_word_o      (read_word_o),
        .flush_i          (flush_i),
        .mem_addr_o       (mem_addr_o),
        .mem_read_en_o    (mem_read_en_o),
        .mem_read_valid_i (mem_read_valid_i),
        .mem_read_data_i  (mem_read_data_i),
        .hit_count_o      (hit_count_o),
        .miss_count_o     (miss_count_o)
    );

    // backing memory contents: a fixed pattern for line 0x100, a per-line signature elsewhere
    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        if (a[31:4] == 28'h10) return 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = {a[27:4], 8'(i)} ^ 32'h5A00_00C3;
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [127:0] l;
        l = line_of(a);
        return l[a[3:2]*32 +: 32];
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [4:0] idx;
        case ($urandom_range(0, 3))
            0, 1:    idx = 5'h10;
            2:       idx = 5'h11;
            default: idx = 5'($urandom_range(0, 31));
        endcase
        return {20'h0, 3'($urandom_range(0, 3)), idx, 4'($urandom_range(0, 15))};
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, output logic [31:0] w, output int lat, output logic [31:0] ma);
        addr_i    = a;
        read_en_i = 1'b1;
        lat       = 0;
        ma        = '0;
        do begin
            tick();
            lat++;
            if (mem_read_en_o) ma = mem_addr_o;
        end while (!read_valid_o && lat < 40);
        if (!read_valid_o) begin
            tests++;
            fails++;
            $display("FAIL req_timeout addr %h: no read_valid after %0d cycles, expected a response", a, lat);
        end
        w = read_word_o;
    endtask

    // reference model: one step per clock edge from the request rules, reset at once
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                m_rr[s] = 0;
                for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
            end
            m_refill = 0; m_fpend = 0; m_addr = '0;
            e_rv = 0; e_mre = 0; e_word = '0; e_maddr = '0; e_hits = 0; e_miss = 0;
        end else begin
            e_rv = 0;
            if (!m_refill) begin
                if (flush_i || m_fpend) begin
                    for (int s = 0; s < SETS; s++) begin
                        m_rr[s] = 0;
                        for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
                    end
                    m_fpend = 0;
                end else if (read_en_i) begin
                    m_set = int'(addr_i[8:4]);
                    m_way = -1;
                    for (int w = 0; w < WAYS; w++)
                        if (m_valid[m_set][w] && m_tag[m_set][w] == addr_i[31:9]) m_way = w;
                    if (m_way >= 0) begin
                        e_rv = 1; e_word = word_of(addr_i);
                        if (e_hits < CMAX) e_hits++;
                    end else begin
                        m_refill = 1; m_addr = addr_i; e_mre = 1; e_maddr = {addr_i[31:4], 4'h0};
                        if (e_miss < CMAX) e_miss++;
                    end
                end
            end else begin
                if (flush_i) m_fpend = 1;
                if (mem_read_valid_i) begin
                    m_set = int'(m_addr[8:4]);
                    m_inv = -1;
                    for (int w = 0; w < WAYS; w++)
                        if (!m_valid[m_set][w] && m_inv < 0) m_inv = w;
                    m_way = m_inv >= 0 ? m_inv : m_rr[m_set];
                    m_valid[m_set][m_way] = 1'b1;
                    m_tag[m_set][m_way]   = m_addr[31:9];
                    m_rr[m_set] = (m_rr[m_set] + 1) % WAYS;
                    m_refill = 0; e_mre = 0;
                    if (read_en_i) begin
                        e_rv = 1; e_word = word_of(m_addr);
                    end
                end
            end
        end
    end

    // compare every cycle on the falling edge
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            cmp("read_valid", 32'(read_valid_o), 32'(e_rv));
            if (e_rv) cmp("read_word", read_word_o, e_word);
            cmp("mem_read_en", 32'(mem_read_en_o), 32'(e_mre));
            if (e_mre) cmp("mem_addr", mem_addr_o, e_maddr);
            cmp("hit_count", 32'(hit_count_o), e_hits);
            cmp("miss_count", 32'(miss_count_o), e_miss);
        end
    end

    // memory responder: single-cycle data pulse mem_lat cycles into each refill request
    initial forever begin
        @(negedge clk);
        if (rst || !mem_read_en_o || mem_read_valid_i) begin
            mem_read_valid_i = 1'b0;
            mem_cnt = 0;
        end else begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                mem_read_valid_i = 1'b1;
                mem_read_data_i  = line_of(mem_addr_o);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] w, ma;
        logic [31:0] stream_exp [4];
        int lat;
        logic seen, dropped;
        stream_exp = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_read_valid", 32'(read_valid_o), 32'h0);
        cmp("reset_mem_read_en", 32'(mem_read_en_o), 32'h0);
        cmp("reset_mem_addr", mem_addr_o, 32'h0);
        cmp("reset_hits", 32'(hit_count_o), 32'h0);
        cmp("reset_misses", 32'(miss_count_o), 32'h0);
        rst = 1'b0;
        tick();

        req(32'h104, w, lat, ma);
        cmp("cold_word", w, 32'h2222_2222);
        cmp("cold_latency", lat, 4);
        cmp("cold_mem_addr", ma, 32'h100);
        cmp("cold_miss_count", 32'(miss_count_o), 1);
        req(32'h10C, w, lat, ma);
        cmp("hit_word", w, 32'h4444_4444);
        cmp("hit_latency", lat, 1);
        cmp("hit_count", 32'(hit_count_o), 1);
        read_en_i = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            addr_i = 32'h100 + 32'(4 * i);
            read_en_i = 1'b1;
            tick();
            cmp("stream_valid", 32'(read_valid_o), 1);
            cmp("stream_word", read_word_o, stream_exp[i]);
        end
        read_en_i = 1'b0;
        tick();
        cmp("stream_valid_drop", 32'(read_valid_o), 0);
        cmp("stream_hit_count", 32'(hit_count_o), 5);

        req(32'h300, w, lat, ma);
        cmp("fill_0x300_latency", lat, 4);
        req(32'h500, w, lat, ma);
        cmp("fill_0x500_latency", lat, 4);
        req(32'h300, w, lat, ma);
        cmp("rr_keep_0x300", lat, 1);
        req(32'h100, w, lat, ma);
        cmp("rr_evicted_0x100", lat, 4);
        cmp("rr_refetch_word", w, 32'h1111_1111);
        cmp("rr_miss_count", 32'(miss_count_o), 4);
        read_en_i = 1'b0;
        tick();

        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        addr_i = 32'h100;
        read_en_i = 1'b1;
        tick();
        cmp("drop_refill_started", 32'(mem_read_en_o), 1);
        addr_i = 32'h700;
        read_en_i = 1'b0;
        seen = read_valid_o;
        for (int i = 0; i < 20 && mem_read_en_o; i++) begin
            tick();
            seen |= read_valid_o;
        end
        tick();
        seen |= read_valid_o;
        cmp("drop_no_response", 32'(seen), 0);
        cmp("drop_refill_done", 32'(mem_read_en_o), 0);
        req(32'h100, w, lat, ma);
        cmp("drop_installed_hit", lat, 1);
        cmp("drop_installed_word", w, 32'h1111_1111);
        cmp("drop_miss_count", 32'(miss_count_o), 5);
        read_en_i = 1'b0;
        tick();

        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        addr_i = 32'h100;
        read_en_i = 1'b1;
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 20 && !read_valid_o; i++) tick();
        cmp("flush_refill_response", 32'(read_valid_o), 1);
        cmp("flush_refill_word", read_word_o, 32'h1111_1111);
        read_en_i = 1'b0;
        tick();
        req(32'h100, w, lat, ma);
        cmp("flush_then_miss", lat, 4);
        cmp("flush_miss_count", 32'(miss_count_o), 7);
        read_en_i = 1'b0;
        tick();

        addr_i = 32'h900;
        read_en_i = 1'b1;
        tick();
        tick();
        cmp("mid_refill_active", 32'(mem_read_en_o), 1);
        rst = 1'b1;
        read_en_i = 1'b0;
        #1;
        cmp("rst_mem_read_en", 32'(mem_read_en_o), 0);
        cmp("rst_read_valid", 32'(read_valid_o), 0);
        cmp("rst_hits", 32'(hit_count_o), 0);
        cmp("rst_misses", 32'(miss_count_o), 0);
        tick();
        rst = 1'b0;
        req(32'h100, w, lat, ma);
        cmp("post_rst_miss", lat, 4);
        cmp("post_rst_miss_count", 32'(miss_count_o), 1);
        read_en_i = 1'b0;
        tick();

        dropped = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (!read_en_i || read_valid_o) begin
                if (dropped && mem_read_en_o) begin
                    read_en_i = 1'b0;
                end else begin
                    dropped = 1'b0;
                    read_en_i = ($urandom % 5) != 0;
                    addr_i = rand_addr();
                end
            end else if (mem_read_en_o && ($urandom % 16) == 0) begin
                read_en_i = 1'b0;
                addr_i = rand_addr();
                dropped = 1'b1;
            end
            flush_i = ($urandom % 32) == 0;
            if (!mem_read_en_o) mem_lat = $urandom_range(1, 4);
            tick();
        end
        read_en_i = 1'b0;
        flush_i = 1'b0;
        repeat (10) tick();
        cmp("saturated_hits", 32'(hit_count_o), 31);
        cmp("saturated_misses", 32'(miss_count_o), 31);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
